// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/acknowledge bus between the memory stage (master) and the data memory (slave).
interface mem_stage_lsu_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// RV64 memory stage + MEM/WB register: store lane alignment, load extension, bus timeout, WB capture.
// Optional: define MEM_MISALIGN_TRAP_EN to suppress misaligned accesses and flag them on wb_err.
module mem_stage_lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [63:0]          pc_in,
  input  logic [2:0]           func3_in,
  input  logic [63:0]          alu_result_in,
  input  logic [63:0]          alu_input2_in,
  input  logic [4:0]           rd_in,
  input  logic                 RegWrite_in,
  input  logic                 MemRead_in,
  input  logic                 MemWrite_in,
  input  logic                 MemReg_in,
  input  logic                 Jump_in,
  mem_stage_lsu_if.master      dmem,
  output logic                 stall_m,
  output logic [63:0]          wb_data,
  output logic [4:0]           wb_rd,
  output logic                 wb_RegWrite,
  output logic                 wb_err
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [2:0]  off;
  logic        mem_op;
  logic        misalign;
  logic        access;
  logic        timeout_hit;
  logic [7:0]  lane_mask;
  logic [63:0] rdata_sh;
  logic [63:0] load_val;
  logic [63:0] wb_sel;

  logic [63:0] wb_data_q;
  logic [4:0]  wb_rd_q;
  logic        wb_regwrite_q;
  logic        wb_err_q;

  assign off    = alu_result_in[2:0];
  assign mem_op = MemRead_in | MemWrite_in;

  // Natural-alignment check; only acts when the trap feature is built in
  always_comb begin
    misalign = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    case (func3_in[1:0])
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = off[0];
      2'b10:   misalign = |off[1:0];
      default: misalign = |off;
    endcase
    misalign = misalign & mem_op;
`endif
  end

  assign access = mem_op & ~misalign;

  // State and timeout counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a non-zero-wait access parks in BUSY until ack or timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (access && !dmem.dmem_ack) begin
          state_d = S_BUSY;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        if (dmem.dmem_ack || timeout_hit || !access) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM outputs; ack beats timeout when both land in the same cycle
  always_comb begin
    timeout_hit   = 1'b0;
    stall_m       = 1'b0;
    dmem.dmem_req = 1'b0;
    if (state_q == S_BUSY && !dmem.dmem_ack && cnt_q == CNT_W'(TIMEOUT - 1)) begin
      timeout_hit = 1'b1;
    end
    stall_m       = access & ~dmem.dmem_ack & ~timeout_hit;
    dmem.dmem_req = access & ~reset & ~timeout_hit;
  end

  always_comb begin
    case (func3_in[1:0])
      2'b00:   lane_mask = 8'h01;
      2'b01:   lane_mask = 8'h03;
      2'b10:   lane_mask = 8'h0F;
      default: lane_mask = 8'hFF;
    endcase
  end

  assign dmem.dmem_we    = MemWrite_in;
  assign dmem.dmem_addr  = {alu_result_in[63:3], 3'b000};
  assign dmem.dmem_wdata = alu_input2_in << {off, 3'b000};
  assign dmem.dmem_wstrb = (MemWrite_in && !misalign) ? (lane_mask << off) : 8'h00;

  // Load extraction and extension
  assign rdata_sh = dmem.dmem_rdata >> {off, 3'b000};

  always_comb begin
    case (func3_in)
      3'b000:  load_val = {{56{rdata_sh[7]}},  rdata_sh[7:0]};
      3'b001:  load_val = {{48{rdata_sh[15]}}, rdata_sh[15:0]};
      3'b010:  load_val = {{32{rdata_sh[31]}}, rdata_sh[31:0]};
      3'b011:  load_val = rdata_sh;
      3'b100:  load_val = {56'd0, rdata_sh[7:0]};
      3'b101:  load_val = {48'd0, rdata_sh[15:0]};
      3'b110:  load_val = {32'd0, rdata_sh[31:0]};
      default: load_val = 64'd0;
    endcase
  end

  assign wb_sel = Jump_in   ? (pc_in + 64'd4) :
                  MemReg_in ? (timeout_hit ? 64'd0 : load_val) :
                              alu_result_in;

  // MEM/WB register: stalled cycles become bubbles with data held
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_data_q     <= '0;
      wb_rd_q       <= '0;
      wb_regwrite_q <= 1'b0;
      wb_err_q      <= 1'b0;
    end else if (stall_m) begin
      wb_rd_q       <= '0;
      wb_regwrite_q <= 1'b0;
      wb_err_q      <= 1'b0;
    end else begin
      wb_data_q     <= wb_sel;
      wb_rd_q       <= rd_in;
      wb_regwrite_q <= RegWrite_in & ~misalign;
      wb_err_q      <= timeout_hit | misalign;
    end
  end

  assign wb_data     = wb_data_q;
  assign wb_rd       = wb_rd_q;
  assign wb_RegWrite = wb_regwrite_q;
  assign wb_err      = wb_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized self-checking bench for mem_stage_lsu against a per-instruction behavioural model.
module tb_mem_stage_lsu;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        reset;
  logic [63:0] pc_in;
  logic [2:0]  func3_in;
  logic [63:0] alu_result_in;
  logic [63:0] alu_input2_in;
  logic [4:0]  rd_in;
  logic        RegWrite_in, MemRead_in, MemWrite_in, MemReg_in, Jump_in;
  logic        stall_m;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_RegWrite;
  logic        wb_err;

  int n_cmp = 0;
  int n_mis = 0;
  logic [63:0] prev_wb;

  mem_stage_lsu_if dmem_if ();

  mem_stage_lsu #(.TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_in         (pc_in),
    .func3_in      (func3_in),
    .alu_result_in (alu_result_in),
    .alu_input2_in (alu_input2_in),
    .rd_in         (rd_in),
    .RegWrite_in   (RegWrite_in),
    .MemRead_in    (MemRead_in),
    .MemWrite_in   (MemWrite_in),
    .MemReg_in     (MemReg_in),
    .Jump_in       (Jump_in),
    .dmem          (dmem_if),
    .stall_m       (stall_m),
    .wb_data       (wb_data),
    .wb_rd         (wb_rd),
    .wb_RegWrite   (wb_RegWrite),
    .wb_err        (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  // Load result: pick bytes starting at the offset, then extend by the func3 rule
  function automatic logic [63:0] ref_load(input logic [2:0] f3, input int off, input logic [63:0] rdata);
    logic [63:0] v, mask;
    int nb;
    v = rdata >> (8 * off);
    if (f3 == 3'd3) return v;
    if (f3 == 3'd7) return 64'd0;
    nb = size_bytes(f3);
    mask = (64'd1 << (8 * nb)) - 64'd1;
    v = v & mask;
    if (f3 < 3'd3 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [7:0] ref_wstrb(input logic [2:0] f3, input int off);
    logic [7:0] s;
    s = 8'h00;
    for (int b = 0; b < 8; b++)
      if (b >= off && b < off + size_bytes(f3)) s[b] = 1'b1;
    return s;
  endfunction

  function automatic logic ref_misalign(input logic memop, input logic [2:0] f3, input int off);
`ifdef MEM_MISALIGN_TRAP_EN
    return memop && ((off % size_bytes(f3)) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // One instruction through the stage; memory acks lat cycles after first request (lat > TIMEOUT => never in time)
  task automatic run_instr(input logic [63:0] pc, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] rs2, input logic [4:0] rd, input logic rw,
                           input logic mr, input logic mw, input logic mreg, input logic jmp,
                           input int lat, input logic [63:0] rdata);
    logic memop, mis, tmo, exp_stall, exp_req;
    int off, done_k;
    logic [63:0] exp_wb;
    off   = int'(addr[2:0]);
    memop = mr | mw;
    mis   = ref_misalign(memop, f3, off);
    tmo   = 1'b0;
    if (!memop || mis) done_k = 0;
    else if (lat <= TIMEOUT) done_k = lat;
    else begin
      done_k = TIMEOUT;
      tmo    = 1'b1;
    end
    exp_wb = jmp ? pc + 64'd4 : mreg ? (tmo ? 64'd0 : ref_load(f3, off, rdata)) : addr;

    @(negedge clk);
    pc_in = pc; func3_in = f3; alu_result_in = addr; alu_input2_in = rs2; rd_in = rd;
    RegWrite_in = rw; MemRead_in = mr; MemWrite_in = mw; MemReg_in = mreg; Jump_in = jmp;
    dmem_if.dmem_rdata = rdata;
    for (int k = 0; k <= done_k; k++) begin
      if (k > 0) @(negedge clk);
      dmem_if.dmem_ack = memop && !mis && (k == lat);
      #1;
      exp_stall = (k < done_k);
      exp_req   = memop && !mis && !(tmo && k == done_k);
      check("stall_m", 64'(stall_m), 64'(exp_stall));
      check("dmem_req", 64'(dmem_if.dmem_req), 64'(exp_req));
      if (exp_req) begin
        check("dmem_addr", dmem_if.dmem_addr, {addr[63:3], 3'b000});
        check("dmem_we", 64'(dmem_if.dmem_we), 64'(mw));
        check("dmem_wstrb", 64'(dmem_if.dmem_wstrb), 64'(mw ? ref_wstrb(f3, off) : 8'h00));
        if (mw) check("dmem_wdata", dmem_if.dmem_wdata, rs2 << (8 * off));
      end
      @(posedge clk);
      #1;
      if (exp_stall) begin
        check("bubble_regwrite", 64'(wb_RegWrite), 64'd0);
        check("bubble_rd", 64'(wb_rd), 64'd0);
        check("bubble_err", 64'(wb_err), 64'd0);
        check("bubble_data_held", wb_data, prev_wb);
      end else begin
        check("wb_data", wb_data, exp_wb);
        check("wb_rd", 64'(wb_rd), 64'(rd));
        check("wb_regwrite", 64'(wb_RegWrite), 64'(rw & ~mis));
        check("wb_err", 64'(wb_err), 64'(tmo | mis));
        prev_wb = exp_wb;
      end
    end
  endtask

  initial begin
    int kind, r, lat;
    logic [2:0] f3;
    logic mr, mw, mreg, jmp;

    reset = 1'b1;
    pc_in = '0; func3_in = '0; alu_result_in = '0; alu_input2_in = '0; rd_in = '0;
    RegWrite_in = 0; MemRead_in = 0; MemWrite_in = 0; MemReg_in = 0; Jump_in = 0;
    dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = '0;
    prev_wb = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_wb_data", wb_data, 64'd0);
    check("reset_wb_rd", 64'(wb_rd), 64'd0);
    check("reset_wb_regwrite", 64'(wb_RegWrite), 64'd0);
    check("reset_wb_err", 64'(wb_err), 64'd0);

    // Reset arriving mid-access
    @(negedge clk);
    reset = 1'b0;
    func3_in = 3'd3; alu_result_in = 64'h3000; rd_in = 5'd7;
    RegWrite_in = 1; MemRead_in = 1; MemReg_in = 1;
    #1;
    check("midrst_req_before", 64'(dmem_if.dmem_req), 64'd1);
    check("midrst_stall_before", 64'(stall_m), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_req_in_reset", 64'(dmem_if.dmem_req), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("midrst_wb_data", wb_data, 64'd0);
    check("midrst_wb_rd", 64'(wb_rd), 64'd0);
    check("midrst_wb_regwrite", 64'(wb_RegWrite), 64'd0);
    check("midrst_wb_err", 64'(wb_err), 64'd0);
    reset = 1'b0;
    prev_wb = 64'd0;

    // Timeout right after reset (exposes any stale FSM/counter state)
    run_instr(64'h100, 3'd3, 64'h3000, 64'd0, 5'd7, 1, 1, 0, 1, 0, 1000, 64'h1234_5678_9ABC_DEF0);
    // Ack in the same cycle the timeout would fire
    run_instr(64'h104, 3'd3, 64'h3008, 64'd0, 5'd8, 1, 1, 0, 1, 0, TIMEOUT, 64'h1234_5678_9ABC_DEF0);
    // SH into top half-word, zero-wait
    run_instr(64'h108, 3'd1, 64'h1006, 64'hABCD, 5'd0, 0, 0, 1, 0, 0, 0, 64'd0);
    check("sh_wstrb_C0", 64'(ref_wstrb(3'd1, 6)), 64'h00C0);
    // LB with three wait cycles
    run_instr(64'h10C, 3'd0, 64'h2003, 64'd0, 5'd3, 1, 1, 0, 1, 0, 3, 64'h0000_0000_8000_0000);
    // LWU / LW of upper word
    run_instr(64'h110, 3'd6, 64'h2004, 64'd0, 5'd4, 1, 1, 0, 1, 0, 1, 64'h89AB_CDEF_0000_0000);
    run_instr(64'h114, 3'd2, 64'h2004, 64'd0, 5'd5, 1, 1, 0, 1, 0, 0, 64'h89AB_CDEF_0000_0000);
    // Jump link with pc+4 wrap
    run_instr(64'hFFFF_FFFF_FFFF_FFFC, 3'd0, 64'h55, 64'd0, 5'd1, 1, 0, 0, 0, 1, 0, 64'd0);
    check("jump_wrap", wb_data, 64'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    run_instr(64'h118, 3'd2, 64'h1002, 64'd0, 5'd6, 1, 1, 0, 1, 0, 0, 64'hDEAD_BEEF_CAFE_F00D);
`endif

    for (int i = 0; i < 300; i++) begin
      kind = int'($urandom_range(0, 9));
      mr = (kind >= 3 && kind <= 6) || kind == 9;
      mw = (kind >= 7);
      f3 = mw ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      mreg = mr && !mw && ($urandom_range(0, 7) != 0);
      jmp  = !mr && !mw && ($urandom_range(0, 5) == 0);
      r = int'($urandom_range(0, 9));
      if (r < 5) lat = r;
      else if (r < 8) lat = int'($urandom_range(5, TIMEOUT));
      else lat = TIMEOUT + 1 + int'($urandom_range(0, 3));
      run_instr({$urandom, $urandom}, f3, {$urandom, $urandom}, {$urandom, $urandom},
                5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), mr, mw, mreg, jmp,
                lat, {$urandom, $urandom});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
